// File: rtl/jtdd_sdram_pkg.sv
// jtdd_sdram_pkg: shared definitions for the JTDD SDRAM controller.
//   - SDRAM command encodings {ncs,nras,ncas,nwe}
//   - controller state enum
//   - mode register value and address-map helpers
package jtdd_sdram_pkg;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    // burst length 2, sequential, CAS latency 2
    localparam logic [12:0] MODE_REG = 13'h021;

    typedef enum logic [3:0] {
        INIT_WAIT,
        INIT_PRE,
        INIT_REF,
        INIT_MRS,
        IDLE,
        ACT,
        RW,
        DATA,
        RECOV
    } state_e;

    function automatic logic [1:0] addr_ba(input logic [21:0] a);
        return a[21:20];
    endfunction

    function automatic logic [12:0] addr_row(input logic [21:0] a);
        return {1'b0, a[19:8]};
    endfunction

    // column with A10 set: every access closes its row by auto-precharge
    function automatic logic [12:0] addr_col(input logic [21:0] a);
        return {2'b00, 1'b1, 2'b00, a[7:0]};
    endfunction

endpackage

// File: rtl/jtdd_sdram_reftimer.sv
// jtdd_sdram_reftimer: refresh obligation timer.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_i      : an AUTO REFRESH was issued, drop the obligation
//   pend_o     : a refresh is owed (saturates at one)
module jtdd_sdram_reftimer #(
    parameter int REF_PERIOD = 374
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic pend_o
);

    localparam logic [15:0] LAST = 16'(REF_PERIOD - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        tick;

    always_comb begin
        tick   = (cnt_q == LAST);
        cnt_d  = tick ? 16'd0 : cnt_q + 16'd1;
        // a new period landing on the clear cycle still counts
        pend_d = tick | (pend_q & ~clr_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= 16'd0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/jtdd_sdram_ctrl.sv
// jtdd_sdram_ctrl: SDRAM responder for the JTDD ROM cache and ROM download.
//   sdram_req/sdram_addr/sdram_ack  : cache read request, ack when accepted
//   data_read/data_rdy              : 32-bit result {word addr+1, word addr}
//   prog_addr/data/mask/we/rd       : download writer and readback strobes
//   refresh_en/downloading          : windows in which refresh may run
//   init_done                       : power-up sequence complete
//   sd_*                            : 16-bit SDR SDRAM pins (registered)
// All SDRAM outputs are registered: a command decided in cycle n is on the
// pins in cycle n+1, so the counters below are loaded one short.
module jtdd_sdram_ctrl
    import jtdd_sdram_pkg::*;
#(
    parameter int INIT_CYCLES = 4800,
    parameter int TRCD        = 2,
    parameter int TRP         = 2,
    parameter int TRFC        = 7,
    parameter int CL          = 2,
    parameter int REF_PERIOD  = 374
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_req,
    input  logic [21:0] sdram_addr,
    output logic        sdram_ack,
    output logic [31:0] data_read,
    output logic        data_rdy,
    input  logic        refresh_en,
    input  logic        downloading,
    input  logic [21:0] prog_addr,
    input  logic [7:0]  prog_data,
    input  logic [1:0]  prog_mask,
    input  logic        prog_we,
    input  logic        prog_rd,
    output logic        init_done,
    output logic        sd_cke,
    output logic [3:0]  sd_cmd,
    output logic [1:0]  sd_ba,
    output logic [12:0] sd_a,
    output logic [1:0]  sd_dqm,
    output logic [15:0] sd_dq_out,
    output logic        sd_dq_oe,
    input  logic [15:0] sd_dq_in
);

    localparam logic [12:0] MODE = {MODE_REG[12:7], 3'(CL), MODE_REG[3:0]};

    localparam logic [15:0] LD_INIT      = 16'(INIT_CYCLES - 1);
    localparam logic [15:0] LD_PRE       = 16'(TRP);
    localparam logic [15:0] LD_RFC       = 16'(TRFC);
    localparam logic [15:0] LD_MRS       = 16'd1;
    localparam logic [15:0] LD_TRCD      = 16'(TRCD - 1);
    localparam logic [15:0] LD_DATA      = 16'(CL);
    // read: first ACT allowed TRP cycles after data_rdy
    localparam logic [15:0] LD_RD_RECOV  = 16'(TRP - 2);
    // write: masked second beat, then TRP of auto-precharge
    localparam logic [15:0] LD_WR_RECOV  = 16'(TRP);
    localparam logic [15:0] LD_REF_RECOV = 16'(TRFC - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ref2_q, ref2_d;
    logic        done_q, done_d;

    logic [3:0]  cmd_q, cmd_d;
    logic [1:0]  ba_q, ba_d;
    logic [12:0] a_q, a_d;
    logic [1:0]  dqm_q, dqm_d;
    logic [15:0] dq_q, dq_d;
    logic        oe_q, oe_d;
    logic        ack_q, ack_d;
    logic        rdy_q, rdy_d;
    logic [31:0] data_q, data_d;
    logic [15:0] lo_q, lo_d;

    logic [21:0] act_addr_q, act_addr_d;
    logic        act_wr_q, act_wr_d;
    logic [7:0]  act_dat_q, act_dat_d;
    logic [1:0]  act_msk_q, act_msk_d;

    // one-deep download latches
    logic        pend_wr_q, pend_rd_q;
    logic [21:0] wr_addr_q, rd_addr_q;
    logic [7:0]  wr_dat_q;
    logic [1:0]  wr_msk_q;
    logic        wr_take, rd_take;

    logic        ref_pend, ref_clr;
    logic        go;
    logic [21:0] go_addr;

    jtdd_sdram_reftimer #(.REF_PERIOD(REF_PERIOD)) u_reftimer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (ref_clr),
        .pend_o (ref_pend)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
        ref2_d     = ref2_q;
        done_d     = done_q;
        cmd_d      = CMD_NOP;
        ba_d       = 2'b00;
        a_d        = 13'h0000;
        dqm_d      = 2'b11;
        dq_d       = 16'h0000;
        oe_d       = 1'b0;
        ack_d      = 1'b0;
        rdy_d      = 1'b0;
        data_d     = data_q;
        lo_d       = lo_q;
        act_addr_d = act_addr_q;
        act_wr_d   = act_wr_q;
        act_dat_d  = act_dat_q;
        act_msk_d  = act_msk_q;
        wr_take    = 1'b0;
        rd_take    = 1'b0;
        ref_clr    = 1'b0;
        go         = 1'b0;
        go_addr    = sdram_addr;

        case (state_q)
            INIT_WAIT: if (cnt_q == 16'd0) begin
                cmd_d   = CMD_PRE;
                a_d     = 13'h0400;     // precharge all banks
                cnt_d   = LD_PRE;
                state_d = INIT_PRE;
            end
            INIT_PRE: if (cnt_q == 16'd0) begin
                cmd_d   = CMD_REF;
                cnt_d   = LD_RFC;
                ref2_d  = 1'b0;
                state_d = INIT_REF;
            end
            INIT_REF: if (cnt_q == 16'd0) begin
                if (!ref2_q) begin
                    cmd_d  = CMD_REF;
                    cnt_d  = LD_RFC;
                    ref2_d = 1'b1;
                end else begin
                    cmd_d   = CMD_MRS;
                    a_d     = MODE;
                    cnt_d   = LD_MRS;
                    state_d = INIT_MRS;
                end
            end
            INIT_MRS: if (cnt_q == 16'd0) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            IDLE: begin
                if (pend_wr_q) begin
                    wr_take   = 1'b1;
                    go        = 1'b1;
                    go_addr   = wr_addr_q;
                    act_wr_d  = 1'b1;
                    act_dat_d = wr_dat_q;
                    act_msk_d = wr_msk_q;
                end else if (ref_pend && (refresh_en || downloading)) begin
                    ref_clr = 1'b1;
                    cmd_d   = CMD_REF;
                    cnt_d   = LD_REF_RECOV;
                    state_d = RECOV;
                end else if (pend_rd_q) begin
                    rd_take  = 1'b1;
                    go       = 1'b1;
                    go_addr  = rd_addr_q;
                    act_wr_d = 1'b0;
                end else if (sdram_req && !downloading) begin
                    ack_d    = 1'b1;
                    go       = 1'b1;
                    act_wr_d = 1'b0;
                end
                if (go) begin
                    cmd_d      = CMD_ACT;
                    ba_d       = addr_ba(go_addr);
                    a_d        = addr_row(go_addr);
                    act_addr_d = go_addr;
                    cnt_d      = LD_TRCD;
                    state_d    = ACT;
                end
            end
            ACT: if (cnt_q == 16'd0) begin
                ba_d    = addr_ba(act_addr_q);
                a_d     = addr_col(act_addr_q);
                state_d = RW;
                if (act_wr_q) begin
                    cmd_d = CMD_WR;
                    dq_d  = {act_dat_q, act_dat_q};
                    oe_d  = 1'b1;
                    dqm_d = act_msk_q;
                end else begin
                    cmd_d = CMD_RD;
                    dqm_d = 2'b00;
                end
            end
            RW: begin
                if (act_wr_q) begin
                    cnt_d   = LD_WR_RECOV;
                    state_d = RECOV;
                end else begin
                    dqm_d   = 2'b00;    // keep the second read beat unmasked
                    cnt_d   = LD_DATA;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q == 16'd1)
                    lo_d = sd_dq_in;
                if (cnt_q == 16'd0) begin
                    data_d  = {sd_dq_in, lo_q};
                    rdy_d   = 1'b1;
                    cnt_d   = LD_RD_RECOV;
                    state_d = RECOV;
                end
            end
            RECOV: if (cnt_q == 16'd0) state_d = IDLE;
            default: state_d = INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INIT_WAIT;
            cnt_q      <= LD_INIT;
            ref2_q     <= 1'b0;
            done_q     <= 1'b0;
            cmd_q      <= CMD_NOP;
            ba_q       <= 2'b00;
            a_q        <= 13'h0000;
            dqm_q      <= 2'b11;
            dq_q       <= 16'h0000;
            oe_q       <= 1'b0;
            ack_q      <= 1'b0;
            rdy_q      <= 1'b0;
            data_q     <= 32'h0;
            lo_q       <= 16'h0000;
            act_addr_q <= 22'h0;
            act_wr_q   <= 1'b0;
            act_dat_q  <= 8'h00;
            act_msk_q  <= 2'b11;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ref2_q     <= ref2_d;
            done_q     <= done_d;
            cmd_q      <= cmd_d;
            ba_q       <= ba_d;
            a_q        <= a_d;
            dqm_q      <= dqm_d;
            dq_q       <= dq_d;
            oe_q       <= oe_d;
            ack_q      <= ack_d;
            rdy_q      <= rdy_d;
            data_q     <= data_d;
            lo_q       <= lo_d;
            act_addr_q <= act_addr_d;
            act_wr_q   <= act_wr_d;
            act_dat_q  <= act_dat_d;
            act_msk_q  <= act_msk_d;
        end
    end

    // a strobe landing on the service cycle re-arms the latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_wr_q <= 1'b0;
            pend_rd_q <= 1'b0;
        end else begin
            pend_wr_q <= prog_we | (pend_wr_q & ~wr_take);
            pend_rd_q <= prog_rd | (pend_rd_q & ~rd_take);
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we) begin
            wr_addr_q <= prog_addr;
            wr_dat_q  <= prog_data;
            wr_msk_q  <= prog_mask;
        end
        if (prog_rd)
            rd_addr_q <= prog_addr;
    end

    assign sd_cke    = 1'b1;
    assign sd_cmd    = cmd_q;
    assign sd_ba     = ba_q;
    assign sd_a      = a_q;
    assign sd_dqm    = dqm_q;
    assign sd_dq_out = dq_q;
    assign sd_dq_oe  = oe_q;
    assign sdram_ack = ack_q;
    assign data_rdy  = rdy_q;
    assign data_read = data_q;
    assign init_done = done_q;

endmodule

// File: tb/tb_jtdd_sdram_ctrl.sv
// Directed bench for jtdd_sdram_ctrl: init order, cache read, download
// write, write/refresh priority, deferred refresh and reset abort.
module tb_jtdd_sdram_ctrl;

    localparam int P = 80;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic [31:0] data_read;
    logic        data_rdy;
    logic        refresh_en;
    logic        downloading;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_rd;
    logic        init_done;
    logic        sd_cke;
    logic [3:0]  sd_cmd;
    logic [1:0]  sd_ba;
    logic [12:0] sd_a;
    logic [1:0]  sd_dqm;
    logic [15:0] sd_dq_out;
    logic        sd_dq_oe;
    logic [15:0] sd_dq_in;

    always #5 clk = ~clk;

    jtdd_sdram_ctrl #(
        .INIT_CYCLES(10), .TRCD(2), .TRP(2), .TRFC(7), .CL(2), .REF_PERIOD(P)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_read(data_read), .data_rdy(data_rdy),
        .refresh_en(refresh_en), .downloading(downloading),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prog_rd(prog_rd),
        .init_done(init_done),
        .sd_cke(sd_cke), .sd_cmd(sd_cmd), .sd_ba(sd_ba), .sd_a(sd_a),
        .sd_dqm(sd_dqm), .sd_dq_out(sd_dq_out), .sd_dq_oe(sd_dq_oe),
        .sd_dq_in(sd_dq_in)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bus monitor: log every non-NOP command with its cycle number
    int          cyc = 0;
    logic [3:0]  lg_cmd[$];
    logic [12:0] lg_a[$];
    int          lg_cyc[$];
    int          n_ref = 0, n_ack = 0, n_rdy = 0, done_cyc = 0;
    logic        done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sd_cmd != C_NOP) begin
            lg_cmd.push_back(sd_cmd);
            lg_a.push_back(sd_a);
            lg_cyc.push_back(cyc);
        end
        if (sd_cmd == C_REF) n_ref++;
        if (sdram_ack) n_ack++;
        if (data_rdy) n_rdy++;
        if (init_done && !done_prev) done_cyc = cyc;
        done_prev = init_done;
    end

    // step to just after the next falling edge
    task automatic nclk(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_cmd(input logic [3:0] c, input int lim, output int ok);
        ok = 0;
        for (int i = 0; i < lim && ok == 0; i++) begin
            nclk(1);
            if (sd_cmd == c) ok = 1;
        end
    endtask

    task automatic wait_ack(input int lim, output int ok);
        ok = 0;
        for (int i = 0; i < lim && ok == 0; i++) begin
            nclk(1);
            if (sdram_ack) ok = 1;
        end
    endtask

    task automatic chk_init(input string tg, input int base);
        int ok;
        int nact;
        ok = 0;
        for (int i = 0; i < 300 && ok == 0; i++) begin
            nclk(1);
            if (init_done) ok = 1;
        end
        chk({tg, "_done"}, 32'(ok), 32'd1);
        if (lg_cmd.size() >= base + 4) begin
            chk({tg, "_pre"},   32'(lg_cmd[base]),       32'(C_PRE));
            chk({tg, "_a10"},   32'(lg_a[base][10]),     32'd1);
            chk({tg, "_ref1"},  32'(lg_cmd[base + 1]),   32'(C_REF));
            chk({tg, "_ref2"},  32'(lg_cmd[base + 2]),   32'(C_REF));
            chk({tg, "_mrs"},   32'(lg_cmd[base + 3]),   32'(C_MRS));
            chk({tg, "_mode"},  32'(lg_a[base + 3]),     32'h021);
            chk({tg, "_dgap"},  32'(done_cyc - lg_cyc[base + 3]), 32'd2);
            nact = 0;
            for (int i = base; i < lg_cmd.size(); i++)
                if (lg_cmd[i] == C_ACT) nact++;
            chk({tg, "_noact"}, 32'(nact), 32'd0);
        end else begin
            chk({tg, "_ncmd"}, 32'(lg_cmd.size() - base), 32'd4);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ok, base, n0, nsync, ack0, rdy0;

        rst_n = 1'b0;  sdram_req = 1'b0;  sdram_addr = '0;
        refresh_en = 1'b0;  downloading = 1'b0;
        prog_addr = '0;  prog_data = '0;  prog_mask = 2'b11;
        prog_we = 1'b0;  prog_rd = 1'b0;  sd_dq_in = '0;
        nclk(3);

        // reset state
        chk("rst_cke",  32'(sd_cke),    32'd1);
        chk("rst_cmd",  32'(sd_cmd),    32'(C_NOP));
        chk("rst_a",    32'(sd_a),      32'd0);
        chk("rst_ba",   32'(sd_ba),     32'd0);
        chk("rst_dqm",  32'(sd_dqm),    32'd3);
        chk("rst_oe",   32'(sd_dq_oe),  32'd0);
        chk("rst_ack",  32'(sdram_ack), 32'd0);
        chk("rst_rdy",  32'(data_rdy),  32'd0);
        chk("rst_data", data_read,      32'd0);
        chk("rst_done", 32'(init_done), 32'd0);

        // power-up init
        base = lg_cmd.size();
        rst_n = 1'b1;
        chk_init("init", base);

        // cache read: addr 312345 -> ba 3, row 123, col 45
        sdram_req = 1'b1;  sdram_addr = 22'h312345;
        wait_ack(20, ok);
        chk("rd_ack", 32'(ok), 32'd1);
        if (ok == 1) begin
            chk("rd_act",  32'(sd_cmd), 32'(C_ACT));
            chk("rd_aba",  32'(sd_ba),  32'd3);
            chk("rd_row",  32'(sd_a),   32'h123);
            sdram_req = 1'b0;
            nclk(1);
            chk("rd_t1",   32'(sd_cmd), 32'(C_NOP));
            nclk(1);
            chk("rd_cmd",  32'(sd_cmd), 32'(C_RD));
            chk("rd_col",  32'(sd_a),   32'h445);
            chk("rd_cba",  32'(sd_ba),  32'd3);
            nclk(2);
            sd_dq_in = 16'hAAAA;
            nclk(1);
            chk("rd_t5",   32'(data_rdy), 32'd0);
            sd_dq_in = 16'h5555;
            nclk(1);
            chk("rd_rdy",  32'(data_rdy), 32'd1);
            chk("rd_data", data_read,     32'h5555AAAA);
            nclk(1);
            chk("rd_rdy1", 32'(data_rdy), 32'd0);
        end
        sd_dq_in = 16'h0000;

        // download write: addr 10, data 3C, high lane only
        nclk(2);
        ack0 = n_ack;
        prog_addr = 22'h000010;  prog_data = 8'h3C;  prog_mask = 2'b01;  prog_we = 1'b1;
        nclk(1);
        prog_we = 1'b0;  downloading = 1'b1;
        wait_cmd(C_ACT, 20, ok);
        chk("wr_act", 32'(ok), 32'd1);
        if (ok == 1) begin
            chk("wr_row",  32'(sd_a),      32'h000);
            nclk(2);
            chk("wr_cmd",  32'(sd_cmd),    32'(C_WR));
            chk("wr_col",  32'(sd_a),      32'h410);
            chk("wr_dq",   32'(sd_dq_out), 32'h3C3C);
            chk("wr_oe",   32'(sd_dq_oe),  32'd1);
            chk("wr_dqm",  32'(sd_dqm),    32'd1);
            nclk(1);
            chk("wr_dqm2", 32'(sd_dqm),    32'd3);
            chk("wr_oe2",  32'(sd_dq_oe),  32'd0);
        end
        nclk(6);
        chk("wr_noack", 32'(n_ack - ack0), 32'd0);
        downloading = 1'b0;

        // write and refresh both pending: write goes first
        nclk(2 * P);
        base = lg_cmd.size();
        prog_addr = 22'h1ABCDE;  prog_data = 8'hA5;  prog_mask = 2'b00;  prog_we = 1'b1;
        nclk(1);
        prog_we = 1'b0;  downloading = 1'b1;
        ok = 0;
        for (int i = 0; i < 40 && ok == 0; i++) begin
            nclk(1);
            if (lg_cmd.size() >= base + 3) ok = 1;
        end
        chk("pri_seen", 32'(ok), 32'd1);
        if (ok == 1) begin
            chk("pri_act", 32'(lg_cmd[base]),     32'(C_ACT));
            chk("pri_wr",  32'(lg_cmd[base + 1]), 32'(C_WR));
            chk("pri_ref", 32'(lg_cmd[base + 2]), 32'(C_REF));
            chk("pri_gap", 32'(lg_cyc[base + 2] - lg_cyc[base] >= 6), 32'd1);
        end
        nclk(10);
        downloading = 1'b0;

        // deferred refresh: lock onto the timer phase, then hold off 3 periods
        refresh_en = 1'b1;
        n0 = n_ref;
        ok = 0;
        for (int i = 0; i < P + 20 && ok == 0; i++) begin
            nclk(1);
            if (n_ref != n0) ok = 1;
        end
        refresh_en = 1'b0;
        chk("ref_sync", 32'(ok), 32'd1);
        nsync = n_ref;
        nclk(3 * P + P / 2);
        chk("ref_held", 32'(n_ref - nsync), 32'd0);
        n0 = n_ref;
        refresh_en = 1'b1;
        nclk(10);
        chk("ref_one",  32'(n_ref - n0), 32'd1);
        nclk(P / 2 + 10);
        chk("ref_next", 32'(n_ref - n0), 32'd2);
        refresh_en = 1'b0;

        // reset at read t3 aborts the access and reruns init
        nclk(2);
        sdram_req = 1'b1;  sdram_addr = 22'h0ABCDE;
        wait_ack(20, ok);
        chk("ra_ack", 32'(ok), 32'd1);
        rdy0 = n_rdy;
        nclk(3);
        rst_n = 1'b0;  sdram_req = 1'b0;
        nclk(1);
        chk("ra_cmd",  32'(sd_cmd),    32'(C_NOP));
        chk("ra_done", 32'(init_done), 32'd0);
        chk("ra_rdy",  32'(data_rdy),  32'd0);
        nclk(2);
        base = lg_cmd.size();
        rst_n = 1'b1;
        chk_init("reinit", base);
        chk("ra_nordy", 32'(n_rdy - rdy0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
